// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and width helper for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int grant_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request bit after last, wrapping around
module rr_pick import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int GW = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last,
  output logic               found,
  output logic [GW-1:0]      idx
);
  always_comb begin
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int c;
      c = (int'(last) + k) % NUM_REQ;
      idx = req[c] ? GW'(c) : idx;
    end
  end
  assign found = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 6,
  parameter int BURST_LEN = 4,
  localparam int GW = grant_w(NUM_REQ),
  localparam int BW = $clog2(BURST_LEN + 1)
) (
  input  logic                          wr_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);
  state_t        state;
  logic [GW-1:0] last;
  logic [BW-1:0] beat_cnt;
  logic          found;
  logic [GW-1:0] idx;
  logic          wr;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (.req(req), .last(last), .found(found), .idx(idx));
  // Write path is combinational so an async reset kills an in-flight write at once
  assign wr           = state == GRANT && req[grant_id] && !fifo_full;
  assign fifo_wr_en   = wr;
  assign ack          = wr ? NUM_REQ'(1) << grant_id : '0;
  assign fifo_data_in = wr ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy         = state == GRANT;
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      last     <= GW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        grant_id <= idx;
        beat_cnt <= '0;
        state    <= GRANT;
      end
    end else if (!req[grant_id]) begin
      last  <= grant_id;
      state <= IDLE;
    end else if (wr) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (beat_cnt == BW'(BURST_LEN - 1)) begin
        last  <= grant_id;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus random traffic against a burst-level model
module tb_fifo_wr_arbiter;
  logic        wr_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [23:0] req_data;
  logic [3:0]  ack;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [5:0]  fifo_data_in;
  logic [1:0]  grant_id;
  logic        busy;
  int errors = 0;
  int checks = 0;
  logic [3:0] preq;
  logic [5:0] pdata [4];
  int mg, mcnt, mlast, mgid, wcount;
  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(6), .BURST_LEN(4)) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .grant_id(grant_id), .busy(busy)
  );
  always #5 wr_clk = ~wr_clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    mg = -1; mcnt = 0; mlast = 3; mgid = 0;
  endtask
  // One cycle: drive at negedge, compare, then advance the model at the rising edge
  task automatic step(input logic f);
    bit w;
    req = preq;
    fifo_full = f;
    for (int i = 0; i < 4; i++) req_data[i*6 +: 6] = pdata[i];
    #1;
    w = mg >= 0 && preq[mg] && !f;
    chk("wr_en", int'(fifo_wr_en), int'(w));
    chk("ack", int'(ack), w ? (1 << mg) : 0);
    chk("data", int'(fifo_data_in), w ? int'(pdata[mg]) : 0);
    chk("busy", int'(busy), int'(mg >= 0));
    chk("grant_id", int'(grant_id), mgid);
    @(posedge wr_clk);
    if (mg < 0) begin
      for (int k = 4; k >= 1; k--) if (preq[(mlast + k) % 4]) mg = (mlast + k) % 4;
      if (mg >= 0) begin mgid = mg; mcnt = 0; end
    end else if (!preq[mg]) begin
      mlast = mg; mg = -1;
    end else if (w) begin
      wcount++;
      pdata[mg] = 6'($urandom);
      mcnt++;
      if (mcnt == 4) begin mlast = mg; mg = -1; end
    end
    @(negedge wr_clk);
  endtask
  initial begin
    int w0;
    int order [$];
    rst_n = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; preq = '0;
    wcount = 0;
    for (int i = 0; i < 4; i++) pdata[i] = 6'($urandom);
    pdata[0] = 6'b101010;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ack", int'(ack), 0);
    chk("rst_wr_en", int'(fifo_wr_en), 0);
    chk("rst_data", int'(fifo_data_in), 0);
    chk("rst_gid", int'(grant_id), 0);
    chk("rst_busy", int'(busy), 0);
    #10 rst_n = 1'b1;
    @(negedge wr_clk);
    preq = 4'b0001;
    step(0);
    req = preq; #1;
    chk("first_ack", int'(ack), 1);
    chk("first_data", int'(fifo_data_in), 6'b101010);
    repeat (4) step(0);
    preq = '0;
    step(0);
    model_reset();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    @(negedge wr_clk);
    preq = 4'b1111;
    w0 = wcount;
    for (int c = 0; c < 25; c++) begin
      if (mg < 0) order.push_back(-1);
      step(0);
      if (order.size() > 0 && order[$] == -1) begin void'(order.pop_back()); order.push_back(mgid); end
    end
    chk("rr_writes", wcount - w0, 20);
    chk("rr_grants", order.size(), 5);
    for (int i = 0; i < order.size(); i++) chk("rr_order", order[i], i % 4);
    preq = 4'b0100;
    w0 = wcount;
    repeat (3) step(0);
    preq = '0;
    step(0);
    chk("early_writes", wcount - w0, 2);
    chk("early_busy", int'(busy), 0);
    chk("early_gid", int'(grant_id), 2);
    preq = 4'b0101;
    step(0);
    chk("next_gid", int'(grant_id), 0);
    preq = '0;
    step(0);
    preq = 4'b0001;
    w0 = wcount;
    step(0); step(0);
    repeat (3) step(1);
    repeat (4) step(0);
    chk("stall_writes", wcount - w0, 4);
    preq = 4'b0010;
    w0 = wcount;
    repeat (4) step(1);
    chk("full_start_writes", wcount - w0, 0);
    repeat (5) step(0);
    chk("full_start_total", wcount - w0, 4);
    preq = 4'b1000;
    repeat (3) step(0);
    req = preq; #1;
    chk("pre_rst_wr", int'(fifo_wr_en), 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_wr", int'(fifo_wr_en), 0);
    chk("mid_rst_ack", int'(ack), 0);
    chk("mid_rst_busy", int'(busy), 0);
    model_reset();
    @(negedge wr_clk);
    rst_n = 1'b1;
    preq = 4'b1001;
    step(0);
    chk("post_rst_gid", int'(grant_id), 0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if (!preq[i] && $urandom_range(2) == 0) preq[i] = 1'b1;
        else if (preq[i] && mg != i && $urandom_range(7) == 0 && !(mg < 0)) preq[i] = preq[i];
      if (mg >= 0 && mcnt > 0 && $urandom_range(5) == 0) preq[mg] = 1'b0;
      step($urandom_range(3) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
